key_debounce_toggle: RTL

- Conditions a raw pushbutton (board KEY) into clean control signals for the LED blinker stage directly downstream.
- Synchronises the asynchronous key to CLOCK_50 and debounces it with a stability counter and FSM.
- Emits a debounced level, one-cycle press/release pulses, and a press-toggled enable that the blinker uses as its run/hold control.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/sync_2ff.sv | 27 ++
 rtl/key_debounce_toggle.sv | 119 +++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the key debounce block and its neighbours:
// FSM state encoding, board clock rate and a ms-to-cycles helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ARM_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_ARM_RELEASE = 2'd3
    } state_t;

    localparam int CLK_HZ = 50_000_000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs (keys, switches).
// Synchronous active-high reset loads both flops with RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_ff1;
    logic r_ff2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ff1 <= RST_VAL;
            r_ff2 <= RST_VAL;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;

endmodule

// File: rtl/key_debounce_toggle.sv
// Pushbutton conditioner: sync, debounce FSM, press/release pulses and
// a press-toggled enable that drives the LED blinker run/hold control.
module key_debounce_toggle
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(20),
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle_q
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_key_sync;
    logic             w_key_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;
    logic             r_toggle;
    logic             w_toggle_nxt;

    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .i_clk (CLOCK_50),
        .i_rst (reset),
        .i_d   (key_in),
        .o_q   (w_key_sync)
    );

    // Normalise polarity so 1 always means pressed.
    assign w_key_s = w_key_sync ^ ACTIVE_LOW;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_toggle  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_toggle  <= w_toggle_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_toggle_nxt  = r_toggle;
        unique case (r_state)
            ST_IDLE: begin
                if (w_key_s) begin
                    w_state_nxt = ST_ARM_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ARM_PRESS: begin
                if (!w_key_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt  = ST_PRESSED;
                    w_cnt_nxt    = '0;
                    w_press_nxt  = 1'b1;
                    w_toggle_nxt = ~r_toggle;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!w_key_s) begin
                    w_state_nxt = ST_ARM_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ARM_RELEASE: begin
                if (w_key_s) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign btn_level     = (r_state == ST_PRESSED) ||
                           (r_state == ST_ARM_RELEASE);
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign toggle_q      = r_toggle;

endmodule
